// File: rtl/apb_motor_ctrl_n.sv
// APB3 slave for NUM_CH DC motor channels: shadowed PWM, registered H-bridge
// drive and a x4 quadrature encoder counter with illegal-transition flag.
module apb_motor_ctrl_n #(
  parameter int NUM_CH    = 2,
  parameter int PWM_WIDTH = 16,
  parameter int ENC_WIDTH = 32
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [7:0]          PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_CH-1:0]   enc_a,
  input  logic [NUM_CH-1:0]   enc_b,
  output logic [NUM_CH-1:0]   pwm,
  output logic [2*NUM_CH-1:0] in_ab
);
  logic                    ch_ok;
  logic                    wr_en;
  logic                    unused;
  logic [NUM_CH:0][31:0]   rd_chain;

  assign ch_ok    = {28'd0, PADDR[7:4]} < 32'(NUM_CH);
  assign wr_en    = PSEL & PENABLE & PWRITE & ch_ok;
  assign PREADY   = 1'b1;
  assign PSLVERR  = PSEL & PENABLE & ~ch_ok;
  assign unused   = ^{PADDR[1:0], PWDATA};

  // At most one channel matches the address, so read data is an OR chain.
  assign rd_chain[0] = '0;
  assign PRDATA      = PSEL ? rd_chain[NUM_CH] : 32'd0;

  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      2'b00:   gray_next = 2'b01;
      2'b01:   gray_next = 2'b11;
      2'b11:   gray_next = 2'b10;
      default: gray_next = 2'b00;
    endcase
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic                 en_reg;
    logic                 err_reg;
    logic [1:0]           mode_reg;
    logic [1:0]           in_ab_reg;
    logic [PWM_WIDTH-1:0] period_reg;
    logic [PWM_WIDTH-1:0] duty_reg;
    logic [PWM_WIDTH-1:0] cnt_reg;
    logic [PWM_WIDTH-1:0] per_act_reg;
    logic [PWM_WIDTH-1:0] duty_act_reg;
    logic [ENC_WIDTH-1:0] count_reg;
    logic [1:0]           sync1_reg;
    logic [1:0]           sync2_reg;
    logic [1:0]           prev_reg;
    logic                 hit;
    logic                 wr_ctrl;
    logic                 wr_per;
    logic                 wr_duty;
    logic                 wr_cnt;
    logic                 step_up;
    logic                 step_dn;
    logic                 step_err;
    logic                 boundary;
    logic [31:0]          rdata;

    assign hit     = PADDR[7:4] == 4'(gi);
    assign wr_ctrl = wr_en && hit && (PADDR[3:2] == 2'd0);
    assign wr_per  = wr_en && hit && (PADDR[3:2] == 2'd1);
    assign wr_duty = wr_en && hit && (PADDR[3:2] == 2'd2);
    assign wr_cnt  = wr_en && hit && (PADDR[3:2] == 2'd3);

    assign step_up  = sync2_reg == gray_next(prev_reg);
    assign step_dn  = prev_reg == gray_next(sync2_reg);
    assign step_err = sync2_reg == ~prev_reg;

    // A zero period is a boundary every cycle so a later non-zero PERIOD is picked up.
    assign boundary = (per_act_reg == '0) || (cnt_reg == per_act_reg - PWM_WIDTH'(1));

    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        en_reg       <= 1'b0;
        err_reg      <= 1'b0;
        mode_reg     <= '0;
        in_ab_reg    <= '0;
        period_reg   <= '0;
        duty_reg     <= '0;
        cnt_reg      <= '0;
        per_act_reg  <= '0;
        duty_act_reg <= '0;
        count_reg    <= '0;
        sync1_reg    <= '0;
        sync2_reg    <= '0;
        prev_reg     <= '0;
      end else begin
        sync1_reg <= {enc_a[gi], enc_b[gi]};
        sync2_reg <= sync1_reg;
        prev_reg  <= sync2_reg;

        if (wr_cnt)       count_reg <= PWDATA[ENC_WIDTH-1:0];
        else if (step_up) count_reg <= count_reg + ENC_WIDTH'(1);
        else if (step_dn) count_reg <= count_reg - ENC_WIDTH'(1);

        if (step_err)                  err_reg <= 1'b1;
        else if (wr_ctrl && PWDATA[8]) err_reg <= 1'b0;

        if (wr_ctrl) begin
          en_reg   <= PWDATA[0];
          mode_reg <= PWDATA[2:1];
        end
        if (wr_per)  period_reg <= PWDATA[PWM_WIDTH-1:0];
        if (wr_duty) duty_reg   <= PWDATA[PWM_WIDTH-1:0];

        if (!en_reg || boundary) begin
          cnt_reg      <= '0;
          per_act_reg  <= period_reg;
          duty_act_reg <= duty_reg;
        end else begin
          cnt_reg <= cnt_reg + PWM_WIDTH'(1);
        end

        in_ab_reg <= en_reg ? {mode_reg[0], mode_reg[1]} : 2'b00;
      end
    end

    assign pwm[gi]            = en_reg && (per_act_reg != '0) && (cnt_reg < duty_act_reg);
    assign in_ab[2*gi+1:2*gi] = in_ab_reg;

    always_comb begin
      rdata = '0;
      case (PADDR[3:2])
        2'd0:    rdata = {23'd0, err_reg, 5'd0, mode_reg, en_reg};
        2'd1:    rdata = 32'(period_reg);
        2'd2:    rdata = 32'(duty_reg);
        default: rdata = 32'($signed(count_reg));
      endcase
    end

    assign rd_chain[gi+1] = rd_chain[gi] | (hit ? rdata : 32'd0);
  end
endmodule

// File: tb/tb_apb_motor_ctrl_n.sv
// Bench for apb_motor_ctrl_n: a 32-bit and an 8-bit encoder instance share one
// bus; a behavioural model is compared against both on every falling edge.
`timescale 1ns/1ps
module tb_apb_motor_ctrl_n;
  localparam int NCH = 2;

  logic            PCLK    = 1'b0;
  logic            PRESERN = 1'b1;
  logic            PSEL    = 1'b0;
  logic            PENABLE = 1'b0;
  logic            PWRITE  = 1'b0;
  logic [7:0]      PADDR   = '0;
  logic [31:0]     PWDATA  = '0;
  logic [NCH-1:0]  enc_a   = '0;
  logic [NCH-1:0]  enc_b   = '0;
  logic [31:0]     prdata_w, prdata_n;
  logic            pready_w, pready_n, pslverr_w, pslverr_n;
  logic [NCH-1:0]  pwm_w, pwm_n;
  logic [2*NCH-1:0] in_ab_w, in_ab_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_motor_ctrl_n #(.NUM_CH(NCH), .PWM_WIDTH(16), .ENC_WIDTH(32)) u_wide (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_w), .PREADY(pready_w),
    .PSLVERR(pslverr_w), .enc_a(enc_a), .enc_b(enc_b), .pwm(pwm_w), .in_ab(in_ab_w)
  );

  apb_motor_ctrl_n #(.NUM_CH(NCH), .PWM_WIDTH(16), .ENC_WIDTH(8)) u_narrow (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_n), .PREADY(pready_n),
    .PSLVERR(pslverr_n), .enc_a(enc_a), .enc_b(enc_b), .pwm(pwm_n), .in_ab(in_ab_n)
  );

  // Behavioural model: register file, position within the running PWM period,
  // signed encoder position, and the pin samples the counter reacts to.
  bit          m_en[NCH];
  bit [1:0]    m_mode[NCH];
  bit          m_err[NCH];
  int unsigned m_per[NCH], m_duty[NCH];
  int unsigned m_pos[NCH], m_cur_per[NCH], m_cur_duty[NCH];
  bit [1:0]    m_drive[NCH];
  bit [31:0]   m_cnt[NCH];
  bit [1:0]    m_h0[NCH], m_h1[NCH], m_h2[NCH];
  bit [1:0]    gray_seq[4]   = '{2'b00, 2'b01, 2'b11, 2'b10};
  bit [1:0]    bridge_tab[4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  function automatic int gray_pos(input bit [1:0] ab);
    for (int k = 0; k < 4; k++)
      if (gray_seq[k] == ab) return k;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input bit narrow);
    int c;
    c = int'(PADDR[7:4]);
    if (!PSEL || c >= NCH) return 32'd0;
    case (PADDR[3:2])
      2'd0:    return {23'd0, m_err[c], 5'd0, m_mode[c], m_en[c]};
      2'd1:    return m_per[c];
      2'd2:    return m_duty[c];
      default: return narrow ? {{24{m_cnt[c][7]}}, m_cnt[c][7:0]} : m_cnt[c];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge PCLK or negedge PRESERN) begin
    int d;
    bit hit;
    bit [1:0] rsel;
    if (!PRESERN) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_mode[c] = 0; m_err[c] = 0; m_per[c] = 0; m_duty[c] = 0;
        m_pos[c] = 0; m_cur_per[c] = 0; m_cur_duty[c] = 0; m_drive[c] = 0;
        m_cnt[c] = 0; m_h0[c] = 0; m_h1[c] = 0; m_h2[c] = 0;
      end
    end else begin
      rsel = PADDR[3:2];
      for (int c = 0; c < NCH; c++) begin
        hit = PSEL && PENABLE && PWRITE && (int'(PADDR[7:4]) == c);
        m_drive[c] = m_en[c] ? bridge_tab[m_mode[c]] : 2'b00;
        if (!m_en[c] || m_cur_per[c] == 0 || m_pos[c] + 1 >= m_cur_per[c]) begin
          m_pos[c]      = 0;
          m_cur_per[c]  = m_per[c];
          m_cur_duty[c] = m_duty[c];
        end else begin
          m_pos[c]++;
        end
        d = (gray_pos(m_h1[c]) - gray_pos(m_h2[c]) + 4) % 4;
        if (hit && rsel == 2'd3) m_cnt[c] = PWDATA;
        else if (d == 1)         m_cnt[c] = m_cnt[c] + 1;
        else if (d == 3)         m_cnt[c] = m_cnt[c] - 1;
        if (d == 2)                                 m_err[c] = 1;
        else if (hit && rsel == 2'd0 && PWDATA[8])  m_err[c] = 0;
        if (hit && rsel == 2'd0) begin
          m_en[c]   = PWDATA[0];
          m_mode[c] = PWDATA[2:1];
        end
        if (hit && rsel == 2'd1) m_per[c]  = PWDATA[15:0];
        if (hit && rsel == 2'd2) m_duty[c] = PWDATA[15:0];
        m_h2[c] = m_h1[c];
        m_h1[c] = m_h0[c];
        m_h0[c] = {enc_a[c], enc_b[c]};
      end
    end
  end

  always @(negedge PCLK) begin
    bit exp_pwm;
    bit exp_slverr;
    for (int c = 0; c < NCH; c++) begin
      exp_pwm = m_en[c] && (m_cur_per[c] != 0) && (m_pos[c] < m_cur_duty[c]);
      check("pwm_wide",     32'(pwm_w[c]),       32'(exp_pwm));
      check("pwm_narrow",   32'(pwm_n[c]),       32'(exp_pwm));
      check("in_ab_wide",   32'(in_ab_w[2*c+:2]), 32'(m_drive[c]));
      check("in_ab_narrow", 32'(in_ab_n[2*c+:2]), 32'(m_drive[c]));
    end
    exp_slverr = PSEL && PENABLE && (int'(PADDR[7:4]) >= NCH);
    check("pready_wide",    32'(pready_w),  32'd1);
    check("pready_narrow",  32'(pready_n),  32'd1);
    check("pslverr_wide",   32'(pslverr_w), 32'(exp_slverr));
    check("pslverr_narrow", 32'(pslverr_n), 32'(exp_slverr));
    check("prdata_wide",    prdata_w, model_read(1'b0));
    check("prdata_narrow",  prdata_n, model_read(1'b1));
  end

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("apb wr addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] dw,
                          output logic [31:0] dn, output logic se);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    dw = prdata_w; dn = prdata_n; se = pslverr_w;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("apb rd addr=0x%02h wide=0x%08h narrow=0x%08h slverr=%0b", a, dw, dn, se);
  endtask

  task automatic enc_step(input int c, input bit fwd);
    int p;
    p = gray_pos({enc_a[c], enc_b[c]});
    p = (p + (fwd ? 1 : 3)) % 4;
    {enc_a[c], enc_b[c]} = gray_seq[p];
  endtask

  task automatic count_high(output int hi);
    hi = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (pwm_w[0]) hi++;
    end
    @(posedge PCLK); #1;
  endtask

  initial begin
    logic [31:0] rw, rn, data;
    logic        se;
    logic [7:0]  addr;
    int          hi;

    #1 PRESERN = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    idle(1);

    for (int a = 0; a < 8; a++) begin
      apb_read(8'(a * 4), rw, rn, se);
      check("reset_read_wide", rw, 32'd0);
      check("reset_read_narrow", rn, 32'd0);
    end
    check("reset_pwm", 32'(pwm_w), 32'd0);
    check("reset_in_ab", 32'(in_ab_w), 32'd0);
    check("reset_pready", 32'(pready_w), 32'd1);

    apb_write(8'h04, 32'd10);
    apb_write(8'h08, 32'd3);
    apb_write(8'h00, 32'h3);
    count_high(hi);
    check("pwm_3_of_10", 32'(hi), 32'd3);
    check("in_ab_fwd", 32'(in_ab_w[1:0]), 32'h2);
    apb_write(8'h08, 32'd7);
    idle(25);
    apb_write(8'h08, 32'd12);
    idle(25);
    count_high(hi);
    check("pwm_full", 32'(hi), 32'd10);
    apb_write(8'h04, 32'd0);
    idle(15);
    count_high(hi);
    check("pwm_zero_period", 32'(hi), 32'd0);
    apb_write(8'h00, 32'h0);
    check("pwm_disable", 32'(pwm_w[0]), 32'd0);
    check("in_ab_before", 32'(in_ab_w[1:0]), 32'h2);
    idle(1);
    check("in_ab_after", 32'(in_ab_w[1:0]), 32'h0);

    repeat (8) begin enc_step(1, 1'b1); idle(4); end
    apb_read(8'h1C, rw, rn, se);
    check("enc_fwd8_wide", rw, 32'd8);
    check("enc_fwd8_narrow", rn, 32'd8);
    repeat (10) begin enc_step(1, 1'b0); idle(4); end
    apb_read(8'h1C, rw, rn, se);
    check("enc_rev10_wide", rw, 32'hFFFF_FFFE);
    check("enc_rev10_narrow", rn, 32'hFFFF_FFFE);
    enc_a[1] = ~enc_a[1];
    enc_b[1] = ~enc_b[1];
    idle(5);
    apb_read(8'h1C, rw, rn, se);
    check("enc_jump_hold", rw, 32'hFFFF_FFFE);
    apb_read(8'h10, rw, rn, se);
    check("enc_err_set", rw, 32'h100);
    apb_write(8'h10, 32'h100);
    apb_read(8'h10, rw, rn, se);
    check("enc_err_clear", rw, 32'h0);

    apb_write(8'h1C, 32'h7F);
    enc_step(1, 1'b1);
    idle(5);
    apb_read(8'h1C, rw, rn, se);
    check("enc8_wrap_narrow", rn, 32'hFFFF_FF80);
    check("enc8_wrap_wide", rw, 32'h80);
    enc_step(1, 1'b1);
    idle(1);
    apb_write(8'h1C, 32'd5);
    idle(5);
    apb_read(8'h1C, rw, rn, se);
    check("enc_write_wins_wide", rw, 32'd5);
    check("enc_write_wins_narrow", rn, 32'd5);

    apb_read(8'h20, rw, rn, se);
    check("bad_ch_slverr", 32'(se), 32'd1);
    check("bad_ch_rdata", rw, 32'd0);
    apb_write(8'h20, 32'hFFFF_FFFF);
    apb_write(8'h24, 32'hFFFF_FFFF);
    apb_read(8'h00, rw, rn, se);
    check("bad_ch_no_write", rw, 32'd0);

    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 5))
        0: begin
          enc_a[t % NCH] = 1'($urandom);
          enc_b[t % NCH] = 1'($urandom);
        end
        1: enc_step(t % NCH, 1'b1);
        2: enc_step(t % NCH, 1'b0);
        default: ;
      endcase
      addr = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      case (addr[3:2])
        2'd0:    data = $urandom & 32'h107;
        2'd1:    data = $urandom_range(0, 20);
        2'd2:    data = $urandom_range(0, 25);
        default: data = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) apb_write(addr, data);
      else apb_read(addr, rw, rn, se);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
    end

    apb_write(8'h00, 32'h0);
    apb_write(8'h04, 32'd10);
    apb_write(8'h08, 32'd5);
    apb_write(8'h00, 32'h3);
    idle(2);
    check("pre_reset_pwm", 32'(pwm_w[0]), 32'd1);
    check("pre_reset_in_ab", 32'(in_ab_w[1:0]), 32'h2);
    #2 PRESERN = 1'b0;
    #1;
    check("async_rst_pwm_wide", 32'(pwm_w), 32'd0);
    check("async_rst_pwm_narrow", 32'(pwm_n), 32'd0);
    check("async_rst_in_ab_wide", 32'(in_ab_w), 32'd0);
    check("async_rst_in_ab_narrow", 32'(in_ab_n), 32'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    idle(1);
    apb_read(8'h04, rw, rn, se);
    check("post_reset_period", rw, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
